// File: rtl/weather_timebase_rain.sv
// Timebase, front-panel mode/clear control and tipping-bucket rain accumulation.
// Button and rain inputs are synchronized, then debounced on the 1 kHz sample tick.

module weather_timebase_rain_debounce #(
  parameter int unsigned N = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample,
  input  logic din,
  output logic fall
);
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] run;
  logic          level;
  logic          done;

  // The run completes on the N-th consecutive differing sample.
  assign done = sample && (sync[1] != level) && (run == CW'(N - 1));
  assign fall = done && !sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '1;
      run   <= '0;
      level <= 1'b1;
    end else begin
      sync <= {sync[0], din};
      if (sample) begin
        if (sync[1] == level) begin
          run <= '0;
        end else if (done) begin
          level <= sync[1];
          run   <= '0;
        end else begin
          run <= run + 1'b1;
        end
      end
    end
  end
endmodule

module weather_timebase_rain #(
  parameter int unsigned CLK_PER_MS = 1000,
  parameter int unsigned DEMO_MS    = 10,
  parameter int unsigned RAIN_STEP  = 20,
  parameter int unsigned BTN_DEB    = 20,
  parameter int unsigned RAIN_DEB   = 5
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        Demo,
  input  logic        nMode,
  input  logic        nStart,
  input  logic        nRain,
  output logic        tick_1kHz,
  output logic        tick_1Hz,
  output logic [2:0]  display_mode,
  output logic        nClear_time,
  output logic        nClear_rain,
  output logic [15:0] total_rain_pulses,
  output logic [3:0]  rain_hundreds_bcd,
  output logic [3:0]  rain_tens_bcd,
  output logic [3:0]  rain_units_bcd,
  output logic [3:0]  rain_tenths_bcd,
  output logic [3:0]  rain_hundredths_bcd
);
  localparam int unsigned CYC_W   = $clog2(CLK_PER_MS);
  localparam logic [3:0]  STEP_LO = 4'(RAIN_STEP % 10);
  localparam logic [3:0]  STEP_HI = 4'((RAIN_STEP / 10) % 10);

  typedef enum logic [2:0] {
    MODE0 = 3'd0,
    MODE1 = 3'd1,
    MODE2 = 3'd2,
    MODE3 = 3'd3,
    MODE4 = 3'd4
  } mode_e;

  logic [CYC_W-1:0] cyc_cnt;
  logic [9:0]       ms_cnt;
  logic [9:0]       ms_term;
  logic             mode_fall;
  logic             start_fall;
  logic             rain_fall;
  mode_e            state;
  logic [19:0]      rain_bcd;
  logic [19:0]      bcd_sum;
  logic [19:0]      bcd_next;
  logic [5:0]       carry;

  assign ms_term = Demo ? 10'(DEMO_MS - 1) : 10'd999;

  // >= rather than == so that switching into demo mode past the short terminal fires at once.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      cyc_cnt   <= '0;
      ms_cnt    <= '0;
      tick_1kHz <= 1'b0;
      tick_1Hz  <= 1'b0;
    end else begin
      tick_1kHz <= 1'b0;
      tick_1Hz  <= 1'b0;
      if (cyc_cnt == CYC_W'(CLK_PER_MS - 1)) begin
        cyc_cnt   <= '0;
        tick_1kHz <= 1'b1;
        if (ms_cnt >= ms_term) begin
          ms_cnt   <= '0;
          tick_1Hz <= 1'b1;
        end else begin
          ms_cnt <= ms_cnt + 1'b1;
        end
      end else begin
        cyc_cnt <= cyc_cnt + 1'b1;
      end
    end
  end

  weather_timebase_rain_debounce #(.N(BTN_DEB)) u_deb_mode (
    .clk(Clock), .rst_n(nReset), .sample(tick_1kHz), .din(nMode), .fall(mode_fall)
  );
  weather_timebase_rain_debounce #(.N(BTN_DEB)) u_deb_start (
    .clk(Clock), .rst_n(nReset), .sample(tick_1kHz), .din(nStart), .fall(start_fall)
  );
  weather_timebase_rain_debounce #(.N(RAIN_DEB)) u_deb_rain (
    .clk(Clock), .rst_n(nReset), .sample(tick_1kHz), .din(nRain), .fall(rain_fall)
  );

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state       <= MODE0;
      nClear_time <= 1'b1;
      nClear_rain <= 1'b1;
    end else begin
      nClear_time <= !start_fall;
      nClear_rain <= !start_fall;
      if (mode_fall) begin
        case (state)
          MODE0:   state <= MODE1;
          MODE1:   state <= MODE2;
          MODE2:   state <= MODE3;
          MODE3:   state <= MODE4;
          default: state <= MODE0;
        endcase
      end
    end
  end

  assign display_mode = state;

  function automatic logic [4:0] digit_add(input logic [3:0] a, input logic [3:0] b,
                                           input logic cin);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    if (s > 5'd9) return {1'b1, 4'(s - 5'd10)};
    return {1'b0, s[3:0]};
  endfunction

  // Digits ordered hundredths (LSB) up to hundreds; carry out of hundreds saturates.
  always_comb begin
    carry    = '0;
    bcd_sum  = '0;
    {carry[1], bcd_sum[3:0]}   = digit_add(rain_bcd[3:0],   STEP_LO, 1'b0);
    {carry[2], bcd_sum[7:4]}   = digit_add(rain_bcd[7:4],   STEP_HI, carry[1]);
    {carry[3], bcd_sum[11:8]}  = digit_add(rain_bcd[11:8],  4'd0,    carry[2]);
    {carry[4], bcd_sum[15:12]} = digit_add(rain_bcd[15:12], 4'd0,    carry[3]);
    {carry[5], bcd_sum[19:16]} = digit_add(rain_bcd[19:16], 4'd0,    carry[4]);
    bcd_next = carry[5] ? 20'h99999 : bcd_sum;
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      total_rain_pulses <= '0;
      rain_bcd          <= '0;
    end else if (!nClear_rain) begin
      total_rain_pulses <= '0;
      rain_bcd          <= '0;
    end else if (rain_fall) begin
      if (total_rain_pulses != '1) total_rain_pulses <= total_rain_pulses + 1'b1;
      rain_bcd <= bcd_next;
    end
  end

  assign rain_hundreds_bcd   = rain_bcd[19:16];
  assign rain_tens_bcd       = rain_bcd[15:12];
  assign rain_units_bcd      = rain_bcd[11:8];
  assign rain_tenths_bcd     = rain_bcd[7:4];
  assign rain_hundredths_bcd = rain_bcd[3:0];
endmodule

// File: tb/tb_weather_timebase_rain.sv
// Directed bench: tick timing, mode cycling, clear strobes, rain BCD accumulation/saturation, reset.

module tb_weather_timebase_rain;
  logic Clock = 1'b0;
  logic nReset = 1'b0;
  logic Demo = 1'b0;
  logic nMode = 1'b1;
  logic nStart = 1'b1;
  logic nRain_a = 1'b1;
  logic nRain_b = 1'b1;

  logic        a_t1k, a_t1hz, a_nct, a_ncr;
  logic [2:0]  a_mode;
  logic [15:0] a_cnt;
  logic [3:0]  a_h, a_t, a_u, a_te, a_hu;
  logic        b_t1k, b_t1hz, b_nct, b_ncr;
  logic [2:0]  b_mode;
  logic [15:0] b_cnt;
  logic [3:0]  b_h, b_t, b_u, b_te, b_hu;
  logic        c_t1k, c_t1hz, c_nct, c_ncr;
  logic [2:0]  c_mode;
  logic [15:0] c_cnt;
  logic [3:0]  c_h, c_t, c_u, c_te, c_hu;
  logic [19:0] a_bcd, b_bcd, c_bcd;

  assign a_bcd = {a_h, a_t, a_u, a_te, a_hu};
  assign b_bcd = {b_h, b_t, b_u, b_te, b_hu};
  assign c_bcd = {c_h, c_t, c_u, c_te, c_hu};

  weather_timebase_rain #(
    .CLK_PER_MS(4), .DEMO_MS(10), .RAIN_STEP(20), .BTN_DEB(20), .RAIN_DEB(5)
  ) dut (
    .Clock(Clock), .nReset(nReset), .Demo(Demo), .nMode(nMode), .nStart(nStart),
    .nRain(nRain_a), .tick_1kHz(a_t1k), .tick_1Hz(a_t1hz), .display_mode(a_mode),
    .nClear_time(a_nct), .nClear_rain(a_ncr), .total_rain_pulses(a_cnt),
    .rain_hundreds_bcd(a_h), .rain_tens_bcd(a_t), .rain_units_bcd(a_u),
    .rain_tenths_bcd(a_te), .rain_hundredths_bcd(a_hu)
  );

  weather_timebase_rain #(
    .CLK_PER_MS(2), .DEMO_MS(10), .RAIN_STEP(20), .BTN_DEB(20), .RAIN_DEB(1)
  ) dut_s20 (
    .Clock(Clock), .nReset(nReset), .Demo(Demo), .nMode(nMode), .nStart(nStart),
    .nRain(nRain_b), .tick_1kHz(b_t1k), .tick_1Hz(b_t1hz), .display_mode(b_mode),
    .nClear_time(b_nct), .nClear_rain(b_ncr), .total_rain_pulses(b_cnt),
    .rain_hundreds_bcd(b_h), .rain_tens_bcd(b_t), .rain_units_bcd(b_u),
    .rain_tenths_bcd(b_te), .rain_hundredths_bcd(b_hu)
  );

  weather_timebase_rain #(
    .CLK_PER_MS(2), .DEMO_MS(10), .RAIN_STEP(37), .BTN_DEB(20), .RAIN_DEB(1)
  ) dut_s37 (
    .Clock(Clock), .nReset(nReset), .Demo(Demo), .nMode(nMode), .nStart(nStart),
    .nRain(nRain_b), .tick_1kHz(c_t1k), .tick_1Hz(c_t1hz), .display_mode(c_mode),
    .nClear_time(c_nct), .nClear_rain(c_ncr), .total_rain_pulses(c_cnt),
    .rain_hundreds_bcd(c_h), .rain_tens_bcd(c_t), .rain_units_bcd(c_u),
    .rain_tenths_bcd(c_te), .rain_hundredths_bcd(c_hu)
  );

  always #5 Clock = ~Clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic wait_1hz(input int limit, output int n);
    n = 0;
    for (int i = 1; i <= limit; i++) begin
      step(1);
      if (a_t1hz) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic press_mode();
    nMode = 1'b0;
    step(100);
    nMode = 1'b1;
    step(100);
  endtask

  task automatic rain_a_pulse();
    nRain_a = 1'b0;
    step(40);
    nRain_a = 1'b1;
    step(40);
  endtask

  task automatic rain_b_pulse();
    nRain_b = 1'b0;
    step(4);
    nRain_b = 1'b1;
    step(4);
  endtask

  initial begin
    int first_k, nk, last, bad, hz_c, hz_k, n, lt, lr, lb;
    first_k = 0; nk = 0; last = 0; bad = 0; hz_c = 0; hz_k = 0;

    step(3);
    check("rst_tick_1kHz", int'(a_t1k), 0);
    check("rst_mode", int'(a_mode), 0);
    check("rst_nclear", int'({a_nct, a_ncr}), 3);
    check("rst_rain", int'(a_cnt) + int'(a_bcd), 0);
    nReset = 1'b1;

    for (int c = 1; c <= 6000; c++) begin
      step(1);
      if (a_t1k) begin
        nk++;
        if (first_k == 0) first_k = c;
        else if (c - last != 4) bad++;
        last = c;
      end
      if (a_t1hz) begin
        hz_c = c;
        hz_k = int'(a_t1k);
        break;
      end
    end
    check("first_tick_1kHz_cycle", first_k, 4);
    check("tick_1kHz_bad_periods", bad, 0);
    check("first_tick_1Hz_cycle", hz_c, 4000);
    check("ticks_to_1Hz", nk, 1000);
    check("tick_1Hz_coincident", hz_k, 1);

    Demo = 1'b1;
    wait_1hz(200, n);
    check("demo_1Hz_period_a", n, 40);
    wait_1hz(200, n);
    check("demo_1Hz_period_b", n, 40);
    Demo = 1'b0;
    step(78);
    Demo = 1'b1;
    wait_1hz(200, n);
    check("demo_rise_late_1Hz", n, 2);
    Demo = 1'b0;

    for (int i = 0; i < 3; i++) rain_b_pulse();
    step(6);
    check("s37_3_count", int'(c_cnt), 3);
    check("s37_3_bcd", int'(c_bcd), 'h00111);
    check("s20_3_bcd", int'(b_bcd), 'h00060);
    for (int i = 0; i < 4996; i++) rain_b_pulse();
    step(6);
    check("s20_4999_count", int'(b_cnt), 4999);
    check("s20_4999_bcd", int'(b_bcd), 'h99980);
    rain_b_pulse();
    rain_b_pulse();
    step(6);
    check("s20_5001_count", int'(b_cnt), 5001);
    check("s20_sat_bcd", int'(b_bcd), 'h99999);
    check("s37_5001_count", int'(c_cnt), 5001);
    check("s37_sat_bcd", int'(c_bcd), 'h99999);

    for (int i = 1; i <= 5; i++) begin
      press_mode();
      check("mode_cycle", int'(a_mode), i % 5);
    end
    nMode = 1'b0;
    step(40);
    nMode = 1'b1;
    step(150);
    check("mode_glitch", int'(a_mode), 0);

    for (int i = 0; i < 7; i++) rain_a_pulse();
    check("rain7_count", int'(a_cnt), 7);
    check("rain7_bcd", int'(a_bcd), 'h00140);

    press_mode();
    press_mode();
    check("mode_before_clear", int'(a_mode), 2);
    lt = 0; lr = 0; lb = 0;
    nStart = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (i == 400) nStart = 1'b1;
      step(1);
      if (!a_nct) lt++;
      if (!a_ncr) lr++;
      if (!a_nct && !a_ncr) lb++;
    end
    check("clear_time_low_cycles", lt, 1);
    check("clear_rain_low_cycles", lr, 1);
    check("clear_both_low_cycles", lb, 1);
    check("clear_mode_kept", int'(a_mode), 2);
    check("clear_count", int'(a_cnt), 0);
    check("clear_bcd", int'(a_bcd), 0);

    rain_a_pulse();
    rain_a_pulse();
    check("pre_sim_count", int'(a_cnt), 2);
    nStart = 1'b0;
    step(60);
    nRain_a = 1'b0;
    step(60);
    nRain_a = 1'b1;
    step(80);
    nStart = 1'b1;
    step(150);
    check("sim_clear_count", int'(a_cnt), 0);
    check("sim_clear_bcd", int'(a_bcd), 0);

    press_mode();
    rain_a_pulse();
    check("pre_reset_mode", int'(a_mode), 3);
    check("pre_reset_count", int'(a_cnt), 1);
    nMode = 1'b0;
    step(40);
    nReset = 1'b0;
    #2;
    check("mid_reset_mode", int'(a_mode), 0);
    check("mid_reset_rain", int'(a_cnt) + int'(a_bcd), 0);
    check("mid_reset_strobes", int'({a_nct, a_ncr}), 3);
    check("mid_reset_ticks", int'({a_t1k, a_t1hz}), 0);
    nMode = 1'b1;
    step(3);
    nReset = 1'b1;
    step(200);
    check("post_reset_mode", int'(a_mode), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
